col_serializer: RTL and testbench
=================================

COL_SERIALIZER -- requirements
Module: col_serializer

Interface
REQ-001 SHALL provide parameter UNDO_PERM, default 1: 1 = apply the column-reverse byte un-permutation before serializing; 0 = serialize raw byte order.
REQ-002 SHALL provide parameter CNT_W, default 16: width of the completed-block counter.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  128-bit block offered.
REQ-006 in_ready  out  1  block accepted when in_valid && in_ready at a rising edge.
REQ-007 in_data  in  128  block in column-reversed layout; byte k = in_data[8k+:8].
REQ-008 col_valid  out  1  column word presented.
REQ-009 col_ready  in  1  column word consumed when col_valid && col_ready at a rising edge.
REQ-010 col_data  out  32  current column word.
REQ-011 col_idx  out  2  index n (0..3) of the current column word.
REQ-012 col_last  out  1  high when col_valid && col_idx == 3.
REQ-013 blk_cnt  out  CNT_W  count of fully emitted blocks.

Function
REQ-014 Captured block S (byte k = S[8k+:8]); original byte j = S byte 4*((15-j) mod 4) + floor((15-j)/4) when UNDO_PERM=1, else S byte j.
REQ-015 Column word n SHALL be original bytes 4n..4n+3, with byte 4n+b at col_data[8b+:8].
REQ-016 FSM states: IDLE (no block held), SEND (block held, col_valid=1).
REQ-017 IDLE: in_ready=1, col_valid=0; on accept -> SEND with col_idx=0, first word valid the next cycle (latency 1 cycle from accept).
REQ-018 SEND: col_idx increments by 1 on each col handshake; col_data, col_idx SHALL remain stable while col_valid && !col_ready.
REQ-019 SEND: in_ready SHALL equal col_ready && col_idx==3 (combinational; no block loss, no skid buffer).
REQ-020 Last-word handshake with simultaneous input accept: load new block, col_idx=0, remain SEND (back-to-back: 4 cycles/block sustained).
REQ-021 Last-word handshake without input accept: -> IDLE, col_valid=0 next cycle.
REQ-022 in_data is sampled only on the accept edge; changes to in_data at other times SHALL NOT affect col_data.
REQ-023 blk_cnt SHALL increment by 1 on each last-word handshake, wrapping from 2^CNT_W-1 to 0.
REQ-024 in_valid while in_ready=0 SHALL have no effect; the source must hold it.
REQ-025 col_idx SHALL read 0 whenever col_valid=0.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE: col_valid=0, col_idx=0, col_data=0, blk_cnt=0; in_ready=0 while rst=1, and in_ready=1 the first cycle after rst deasserts.
REQ-027 rst mid-block SHALL discard the held block without incrementing blk_cnt; handshakes in the rst cycle are ignored.

Verification
REQ-028 UNDO_PERM=1, in_data byte j = j (0x0F0E..0100), col_ready=1 -> words 0x03070B0F, 0x02060A0E, 0x0105090D, 0x0004080C on idx 0..3, col_last on idx 3, blk_cnt=1.
REQ-029 UNDO_PERM=0, same block -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
REQ-030 in_valid held high, 3 blocks, col_ready=1 -> 12 consecutive valid words, no bubble, in_ready pulses only on idx 3, blk_cnt=3.
REQ-031 col_ready low for 5 cycles at idx 1 -> col_data/col_idx stable, in_ready=0 throughout, sequence resumes unchanged.
REQ-032 rst asserted at idx 2 -> col_valid=0, blk_cnt=0 next cycle; next block emits from idx 0.
REQ-033 CNT_W=2, 5 blocks -> blk_cnt 1,2,3,0,1.

Source files
------------

// File: rtl/col_serializer.sv
// Serializes a 128-bit column-reversed block into four 32-bit column words,
// optionally undoing the column-reverse byte permutation on capture.
module col_serializer #(
    parameter int unsigned UNDO_PERM = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             col_valid,
    input  logic             col_ready,
    output logic [31:0]      col_data,
    output logic [1:0]       col_idx,
    output logic             col_last,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [127:0]       data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       in_perm;
    logic               accept;

    // Reorder on capture so the output path is a plain 32-bit word select.
    for (genvar j = 0; j < 16; j++) begin : g_perm
        localparam int unsigned Src = (UNDO_PERM != 0) ? 4 * ((15 - j) % 4) + (15 - j) / 4 : j;
        assign in_perm[8*j +: 8] = in_data[8*Src +: 8];
    end

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle:  in_ready = 1'b1;
                StSend:  in_ready = col_ready && (idx_q == 2'd3);
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StSend;
                    idx_d   = 2'd0;
                    data_d  = in_perm;
                end
            end
            StSend: begin
                if (col_ready) begin
                    if (idx_q == 2'd3) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        idx_d = 2'd0;
                        if (accept) begin
                            data_d = in_perm;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign col_valid = (state_q == StSend);
    assign col_idx   = idx_q;
    assign col_last  = col_valid && (idx_q == 2'd3);
    assign col_data  = col_valid ? data_q[32*idx_q +: 32] : 32'h0;
    assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_col_serializer.sv
// Directed bench for col_serializer: permuted, raw and 2-bit-counter instances
// share one stimulus stream.
module tb_col_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         col_ready = 1'b0;

    logic        rdy_p, val_p, last_p;
    logic [31:0] data_p;
    logic [1:0]  idx_p;
    logic [15:0] cnt_p;

    logic        rdy_r, val_r, last_r;
    logic [31:0] data_r;
    logic [1:0]  idx_r;
    logic [15:0] cnt_r;

    logic        rdy_w, val_w, last_w;
    logic [31:0] data_w;
    logic [1:0]  idx_w;
    logic [1:0]  cnt_w;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_p [4] = '{32'h03070B0F, 32'h02060A0E, 32'h0105090D, 32'h0004080C};
    logic [31:0] exp_r [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

    always #5 clk = ~clk;

    col_serializer #(.UNDO_PERM(1), .CNT_W(16)) dut_p (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_p), .in_data(in_data),
        .col_valid(val_p), .col_ready(col_ready), .col_data(data_p), .col_idx(idx_p),
        .col_last(last_p), .blk_cnt(cnt_p)
    );

    col_serializer #(.UNDO_PERM(0), .CNT_W(16)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r), .in_data(in_data),
        .col_valid(val_r), .col_ready(col_ready), .col_data(data_r), .col_idx(idx_r),
        .col_last(last_r), .blk_cnt(cnt_r)
    );

    col_serializer #(.UNDO_PERM(1), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .in_data(in_data),
        .col_valid(val_w), .col_ready(col_ready), .col_data(data_w), .col_idx(idx_w),
        .col_last(last_w), .blk_cnt(cnt_w)
    );

    // Block bk: byte j = 16*bk + j, so every expected word shifts by bk*0x10101010.
    function automatic logic [127:0] blk(input int bk);
        logic [127:0] b;
        for (int j = 0; j < 16; j++) b[8*j +: 8] = 8'(16 * bk + j);
        return b;
    endfunction

    task automatic send_block(input int bk);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = blk(bk);
        col_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; col_ready = 1'b1; in_data = blk(0);
        repeat (2) @(negedge clk);
        checks++; if (val_p !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", val_p); end
        checks++; if (idx_p !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx_p); end
        checks++; if (data_p !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_p); end
        checks++; if (cnt_p !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt_p); end
        checks++; if (rdy_p !== 1'b0) begin errors++; $display("FAIL reset_inready got %b want 0", rdy_p); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (rdy_p !== 1'b1) begin errors++; $display("FAIL post_reset_inready got %b want 1", rdy_p); end
    endtask

    task automatic test_single;
        @(negedge clk);
        in_valid = 1'b1; in_data = blk(0); col_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {4{32'hDEADBEEF}};  // must not disturb the held block
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++; if (val_p !== 1'b1) begin errors++; $display("FAIL single_valid n=%0d got %b want 1", n, val_p); end
            checks++; if (idx_p !== 2'(n)) begin errors++; $display("FAIL single_idx got %0d want %0d", idx_p, n); end
            checks++; if (data_p !== exp_p[n]) begin errors++; $display("FAIL single_perm n=%0d got %h want %h", n, data_p, exp_p[n]); end
            checks++; if (data_r !== exp_r[n]) begin errors++; $display("FAIL single_raw n=%0d got %h want %h", n, data_r, exp_r[n]); end
            checks++; if (last_p !== (n == 3)) begin errors++; $display("FAIL single_last n=%0d got %b want %b", n, last_p, n == 3); end
            checks++; if (rdy_p !== (n == 3)) begin errors++; $display("FAIL single_inready n=%0d got %b want %b", n, rdy_p, n == 3); end
            @(negedge clk);
        end
        #1;
        checks++; if (val_p !== 1'b0) begin errors++; $display("FAIL single_done_valid got %b want 0", val_p); end
        checks++; if (idx_p !== 2'd0) begin errors++; $display("FAIL single_done_idx got %0d want 0", idx_p); end
        checks++; if (cnt_p !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", cnt_p); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1'b1; in_data = blk(0); col_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_data = blk(i / 4 + 1);
            if (i == 11) in_valid = 1'b0;
            #1;
            checks++; if (val_p !== 1'b1) begin errors++; $display("FAIL b2b_valid i=%0d got %b want 1", i, val_p); end
            checks++; if (idx_p !== 2'(i % 4)) begin errors++; $display("FAIL b2b_idx i=%0d got %0d want %0d", i, idx_p, i % 4); end
            checks++; if (data_p !== exp_p[i % 4] + 32'(i / 4) * 32'h10101010) begin
                errors++; $display("FAIL b2b_perm i=%0d got %h want %h", i, data_p, exp_p[i % 4] + 32'(i / 4) * 32'h10101010); end
            checks++; if (data_r !== exp_r[i % 4] + 32'(i / 4) * 32'h10101010) begin
                errors++; $display("FAIL b2b_raw i=%0d got %h want %h", i, data_r, exp_r[i % 4] + 32'(i / 4) * 32'h10101010); end
            checks++; if (rdy_p !== (i % 4 == 3)) begin errors++; $display("FAIL b2b_inready i=%0d got %b want %b", i, rdy_p, i % 4 == 3); end
        end
        @(negedge clk);
        checks++; if (val_p !== 1'b0) begin errors++; $display("FAIL b2b_done_valid got %b want 0", val_p); end
        checks++; if (cnt_p !== 16'd4) begin errors++; $display("FAIL b2b_cnt got %0d want 4", cnt_p); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        in_valid = 1'b1; in_data = blk(0); col_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);  // word 0 consumed, now at idx 1
        col_ready = 1'b0; in_valid = 1'b1; in_data = blk(2);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (idx_p !== 2'd1) begin errors++; $display("FAIL stall_idx c=%0d got %0d want 1", c, idx_p); end
            checks++; if (data_p !== exp_p[1]) begin errors++; $display("FAIL stall_data c=%0d got %h want %h", c, data_p, exp_p[1]); end
            checks++; if (rdy_p !== 1'b0) begin errors++; $display("FAIL stall_inready c=%0d got %b want 0", c, rdy_p); end
            @(negedge clk);
        end
        in_valid = 1'b0; col_ready = 1'b1;
        for (int n = 1; n < 4; n++) begin
            #1;
            checks++; if (idx_p !== 2'(n)) begin errors++; $display("FAIL stall_resume_idx got %0d want %0d", idx_p, n); end
            checks++; if (data_p !== exp_p[n]) begin errors++; $display("FAIL stall_resume_data n=%0d got %h want %h", n, data_p, exp_p[n]); end
            @(negedge clk);
        end
        #1;
        checks++; if (cnt_p !== 16'd5) begin errors++; $display("FAIL stall_cnt got %0d want 5", cnt_p); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_valid = 1'b1; in_data = blk(1); col_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (idx_p !== 2'd2) begin errors++; $display("FAIL rstmid_pre_idx got %0d want 2", idx_p); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (val_p !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", val_p); end
        checks++; if (cnt_p !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", cnt_p); end
        checks++; if (data_p !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h want 0", data_p); end
        @(negedge clk);
        in_valid = 1'b1; in_data = blk(0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (idx_p !== 2'd0) begin errors++; $display("FAIL rstmid_new_idx got %0d want 0", idx_p); end
        checks++; if (data_p !== exp_p[0]) begin errors++; $display("FAIL rstmid_new_data got %h want %h", data_p, exp_p[0]); end
        repeat (4) @(negedge clk);
        checks++; if (cnt_p !== 16'd1) begin errors++; $display("FAIL rstmid_cnt_after got %0d want 1", cnt_p); end
    endtask

    task automatic test_cnt_wrap;
        logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 5; b++) begin
            send_block(b % 3);
            checks++; if (cnt_w !== want[b]) begin errors++; $display("FAIL wrap_cnt b=%0d got %0d want %0d", b, cnt_w, want[b]); end
        end
        checks++; if (cnt_p !== 16'd5) begin errors++; $display("FAIL wrap_wide_cnt got %0d want 5", cnt_p); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
